cache_mem_arbiter: RTL
======================

CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

Interface
REQ-001 Parameter: MEM_LATENCY, 4, cycles from a read issue (mem_enable=1, mem_wr=0) to mem_data_valid for that read.
REQ-002 Parameter: BLOCK_WORDS, 8, 16-bit words per cache block; a block is 16 bytes.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset; asynchronous, active-low.
REQ-005 i_miss_req  in  1  I-cache block-fill request; held until i_fill_done.
REQ-006 i_miss_addr  in  16  I-cache miss byte address.
REQ-007 d_miss_req  in  1  D-cache block-fill request; held until d_fill_done.
REQ-008 d_miss_addr  in  16  D-cache miss byte address.
REQ-009 d_wr_req  in  1  D-cache write-through request; held until d_wr_ack.
REQ-010 d_wr_addr, d_wr_data  in  16 each  write address and data.
REQ-011 i_fill_valid, d_fill_valid  out  1 each  fill word present on fill_data for that cache.
REQ-012 fill_data  out  16  returned word, shared by both caches.
REQ-013 fill_word  out  3  word index within block (0..7) for the current fill word.
REQ-014 i_fill_done, d_fill_done  out  1 each  one-cycle pulse coincident with word 7.
REQ-015 d_wr_ack  out  1  one-cycle pulse; write committed to memory this cycle.
REQ-016 i_busy, d_busy  out  1 each  arbiter currently owned by that cache.
REQ-017 mem_enable, mem_wr  out  1 each  memory command strobes.
REQ-018 mem_addr, mem_data_in  out  16 each  memory address and write data.
REQ-019 mem_data_out  in  16  memory read data; mem_data_valid  in  1  read data valid.

Function
REQ-020 States: IDLE, FILL, WRITE; only IDLE samples requests.
REQ-021 Fixed priority in IDLE: d_miss_req > d_wr_req > i_miss_req; losers wait and their requests stay pending.
REQ-022 Grant edge: IDLE->FILL (or WRITE); owner busy flag rises the following cycle.
REQ-023 FILL issue: in the BLOCK_WORDS cycles after grant, drive mem_enable=1, mem_wr=0, mem_addr={miss_addr[15:4], k[2:0], 1'b0}, where k counts 0..7, one read per cycle.
REQ-024 FILL return: each cycle mem_data_valid=1 in FILL, drive fill_data=mem_data_out and assert owner's fill_valid combinationally; fill_word counts 0..7 in return order.
REQ-025 When word 7 returns, assert owner's fill_done, then go to IDLE; a fill occupies BLOCK_WORDS+MEM_LATENCY cycles (12 at default).
REQ-026 WRITE: one cycle with mem_enable=1, mem_wr=1, mem_addr=d_wr_addr, mem_data_in=d_wr_data, d_wr_ack=1, then IDLE.
REQ-027 A new grant is possible on the same edge that leaves FILL/WRITE only via IDLE; back-to-back transactions have one IDLE cycle between them.
REQ-028 A requester deasserting req mid-FILL does not abort; the fill completes and the done pulse still fires.
REQ-029 mem_data_valid while in IDLE or WRITE is ignored: no fill_valid, counters unchanged.
REQ-030 Outside FILL/WRITE, mem_enable=0, mem_wr=0, all fill_valid/done/ack=0.
REQ-031 The non-owner's fill_valid and fill_done never assert.

Reset
REQ-032 rst_n low: state=IDLE, issue and return counters=0, all outputs 0, immediately (asynchronous).
REQ-033 Reset mid-FILL aborts the fill: no done pulse, and returning stale data is discarded per REQ-029.
REQ-034 The first grant is possible at the first rising edge with rst_n high.

Structure
REQ-035 The shared package holds the state enum (IDLE/FILL/WRITE), BLOCK_BYTES=16, WORD_IDX_W=3, and the default MEM_LATENCY.
REQ-036 One sub-module, arb_word_counter (3-bit counter with clear/enable/terminal-count), is instantiated twice: once for issue, once for return.

Verification
REQ-037 I-miss 0x1236 alone -> reads to 0x1230,0x1232..0x123E on 8 consecutive cycles; words 0..7 return at +4; i_fill_done with word 7; 12 cycles total.
REQ-038 d_miss_req and i_miss_req asserted on the same edge -> D fill completes first; I fill starts after one IDLE cycle.
REQ-039 d_wr_req addr 0x0040 data 0xBEEF while I fill is active -> write waits; then one cycle mem_wr=1, addr 0x0040, data 0xBEEF, d_wr_ack=1.
REQ-040 rst_n low during word 3 return -> outputs 0 immediately; remaining valids are ignored; no done; a fresh fill after reset is correct.
REQ-041 mem_data_valid pulsed while IDLE -> no fill_valid, no counter change.
REQ-042 D req dropped at word 2 -> fill still completes and d_fill_done pulses.

Source files
------------

// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types and constants for the I/D cache block-fill and write-through arbiter.
package cache_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_t;

    localparam int ADDR_W              = 16;
    localparam int DATA_W              = 16;
    localparam int BLOCK_BYTES         = 16;
    localparam int WORD_IDX_W          = 3;
    localparam int BLOCK_OFFSET_W      = $clog2(BLOCK_BYTES);
    localparam int DEFAULT_MEM_LATENCY = 4;

    // Byte address of 16-bit word k inside the block whose upper address bits are blk.
    function automatic logic [ADDR_W-1:0] block_word_addr(
        input logic [ADDR_W-1:BLOCK_OFFSET_W] blk,
        input logic [WORD_IDX_W-1:0]          k
    );
        return {blk, k, 1'b0};
    endfunction

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Cache-side request/fill signals and memory-side command/data signals of the arbiter.
interface cache_mem_arbiter_if;
    import cache_mem_arbiter_pkg::*;

    logic                  i_miss_req;
    logic [ADDR_W-1:0]     i_miss_addr;
    logic                  d_miss_req;
    logic [ADDR_W-1:0]     d_miss_addr;
    logic                  d_wr_req;
    logic [ADDR_W-1:0]     d_wr_addr;
    logic [DATA_W-1:0]     d_wr_data;
    logic                  i_fill_valid;
    logic                  d_fill_valid;
    logic [DATA_W-1:0]     fill_data;
    logic [WORD_IDX_W-1:0] fill_word;
    logic                  i_fill_done;
    logic                  d_fill_done;
    logic                  d_wr_ack;
    logic                  i_busy;
    logic                  d_busy;
    logic                  mem_enable;
    logic                  mem_wr;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_data_in;
    logic [DATA_W-1:0]     mem_data_out;
    logic                  mem_data_valid;

    // slave: the arbiter itself
    modport slave (
        input  i_miss_req, i_miss_addr, d_miss_req, d_miss_addr,
        input  d_wr_req, d_wr_addr, d_wr_data, mem_data_out, mem_data_valid,
        output i_fill_valid, d_fill_valid, fill_data, fill_word,
        output i_fill_done, d_fill_done, d_wr_ack, i_busy, d_busy,
        output mem_enable, mem_wr, mem_addr, mem_data_in
    );

    // master: the caches and memory around the arbiter
    modport master (
        output i_miss_req, i_miss_addr, d_miss_req, d_miss_addr,
        output d_wr_req, d_wr_addr, d_wr_data, mem_data_out, mem_data_valid,
        input  i_fill_valid, d_fill_valid, fill_data, fill_word,
        input  i_fill_done, d_fill_done, d_wr_ack, i_busy, d_busy,
        input  mem_enable, mem_wr, mem_addr, mem_data_in
    );

endinterface

// File: rtl/cache_mem_arbiter_word_counter.sv
// Word index counter within a block: clear has priority, wraps after LAST, tc flags LAST.
module arb_word_counter
    import cache_mem_arbiter_pkg::*;
#(
    parameter logic [WORD_IDX_W-1:0] LAST = '1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  enable,
    output logic [WORD_IDX_W-1:0] count,
    output logic                  tc
);

    logic [WORD_IDX_W-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= tc ? '0 : count_reg + 1'b1;
        end
    end

    assign count = count_reg;
    assign tc    = (count_reg == LAST);

endmodule

// File: rtl/cache_mem_arbiter.sv
// Fixed-priority arbiter sharing one pipelined memory between I-cache fills,
// D-cache fills and D-cache write-through stores.
module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
#(
    parameter int MEM_LATENCY = DEFAULT_MEM_LATENCY,
    parameter int BLOCK_WORDS = BLOCK_BYTES / 2
) (
    input  logic               clk,
    input  logic               rst_n,
    cache_mem_arbiter_if.slave bus
);

    localparam logic [WORD_IDX_W-1:0] LAST_WORD = WORD_IDX_W'(BLOCK_WORDS - 1);

    arb_state_t                       state_reg, state_next;
    owner_t                           owner_reg, owner_next;
    logic [ADDR_W-1:BLOCK_OFFSET_W]   block_reg, block_next;
    logic                             issue_done_reg, issue_done_next;
    logic [WORD_IDX_W-1:0]            issue_count, ret_count;
    logic                             issue_tc, ret_tc;
    logic                             in_fill, issue_en, ret_accept;

    assign in_fill  = (state_reg == FILL);
    assign issue_en = in_fill && !issue_done_reg;

    // A valid earlier than MEM_LATENCY cycles into a fill cannot answer one of its
    // reads; it is a leftover from a fill aborted by reset and is dropped.
    assign ret_accept = in_fill && bus.mem_data_valid &&
                        (issue_done_reg || int'(issue_count) >= MEM_LATENCY);

    assign issue_done_next = in_fill && (issue_done_reg || (issue_en && issue_tc));

    arb_word_counter #(.LAST(LAST_WORD)) u_issue_ctr (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (!in_fill),
        .enable (issue_en),
        .count  (issue_count),
        .tc     (issue_tc)
    );

    arb_word_counter #(.LAST(LAST_WORD)) u_ret_ctr (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (!in_fill),
        .enable (ret_accept),
        .count  (ret_count),
        .tc     (ret_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            owner_reg      <= OWNER_I;
            block_reg      <= '0;
            issue_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            owner_reg      <= owner_next;
            block_reg      <= block_next;
            issue_done_reg <= issue_done_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        owner_next       = owner_reg;
        block_next       = block_reg;
        bus.i_fill_valid = 1'b0;
        bus.d_fill_valid = 1'b0;
        bus.fill_data    = '0;
        bus.fill_word    = '0;
        bus.i_fill_done  = 1'b0;
        bus.d_fill_done  = 1'b0;
        bus.d_wr_ack     = 1'b0;
        bus.mem_enable   = 1'b0;
        bus.mem_wr       = 1'b0;
        bus.mem_addr     = '0;
        bus.mem_data_in  = '0;
        bus.i_busy       = (state_reg != IDLE) && (owner_reg == OWNER_I);
        bus.d_busy       = (state_reg != IDLE) && (owner_reg == OWNER_D);

        case (state_reg)
            IDLE: begin
                if (bus.d_miss_req) begin
                    state_next = FILL;
                    owner_next = OWNER_D;
                    block_next = bus.d_miss_addr[ADDR_W-1:BLOCK_OFFSET_W];
                end else if (bus.d_wr_req) begin
                    state_next = WRITE;
                    owner_next = OWNER_D;
                end else if (bus.i_miss_req) begin
                    state_next = FILL;
                    owner_next = OWNER_I;
                    block_next = bus.i_miss_addr[ADDR_W-1:BLOCK_OFFSET_W];
                end
            end
            FILL: begin
                bus.mem_enable = issue_en;
                bus.mem_addr   = issue_en ? block_word_addr(block_reg, issue_count) : '0;
                if (ret_accept) begin
                    bus.fill_data    = bus.mem_data_out;
                    bus.fill_word    = ret_count;
                    bus.i_fill_valid = (owner_reg == OWNER_I);
                    bus.d_fill_valid = (owner_reg == OWNER_D);
                    bus.i_fill_done  = ret_tc && (owner_reg == OWNER_I);
                    bus.d_fill_done  = ret_tc && (owner_reg == OWNER_D);
                    if (ret_tc) begin
                        state_next = IDLE;
                    end
                end
            end
            WRITE: begin
                bus.mem_enable  = 1'b1;
                bus.mem_wr      = 1'b1;
                bus.mem_addr    = bus.d_wr_addr;
                bus.mem_data_in = bus.d_wr_data;
                bus.d_wr_ack    = 1'b1;
                state_next      = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
